// File: rtl/dmem_responder_pkg.sv
// Shared constants and helpers for the data-memory responder and its SRAM model.
// FSM encodings stay plain localparams so older tools and netlists see fixed values.
package dmem_responder_pkg;

    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WAIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // True when the byte address lies beyond the 8*2^addr_w byte SRAM window.
    function automatic logic addr_oob(input logic [63:0] addr, input int unsigned addr_w);
        return (addr >> (addr_w + 32'd3)) != 64'd0;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// EX-stage load/store request and response bundle.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic              mem_rd_en;
    logic [63:0]       addr_mem_rd;
    logic              mem_wr_en;
    logic [63:0]       addr_mem_wr;
    logic [DATA_W-1:0] data_mem_wr;
    logic [STRB_W-1:0] strb_mem_wr;
    logic              mem_except;
    logic              mem_stall;
    logic [DATA_W-1:0] data_mem_rd;
    logic              mem_rd_valid;
    logic              mem_wr_done;
    logic              mem_resp_err;

    modport master (
        output mem_rd_en, addr_mem_rd, mem_wr_en, addr_mem_wr, data_mem_wr, strb_mem_wr, mem_except,
        input  mem_stall, data_mem_rd, mem_rd_valid, mem_wr_done, mem_resp_err
    );

    modport slave (
        input  mem_rd_en, addr_mem_rd, mem_wr_en, addr_mem_wr, data_mem_wr, strb_mem_wr, mem_except,
        output mem_stall, data_mem_rd, mem_rd_valid, mem_wr_done, mem_resp_err
    );
endinterface

// File: rtl/dmem_sram.sv
// Behavioural single-port 64-bit SRAM with byte mask and RD_LAT-cycle read latency.
// Latency 1 is a combinational read; each extra cycle adds one output register.
module dmem_sram #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wmask,
    output logic [63:0]       rdata
);

    // NOTE: storage arrays carry no reset; clearing them would force flop-based memory.
    logic [63:0] mem_q [2**ADDR_W];
    logic [63:0] rd_comb;

    always_ff @(posedge clk) begin
        if (cs && we) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rd_comb = mem_q[addr];

    generate
        if (RD_LAT == 1) begin : g_comb_rd
            assign rdata = rd_comb;
        end else begin : g_pipe_rd
            logic [63:0] pipe_q [RD_LAT-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= rd_comb;
                for (int i = 1; i < RD_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign rdata = pipe_q[RD_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: turns EX load/store requests into single-port SRAM cycles,
// store before load, holding the pipeline until the response is ready.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    ex,
    output logic               sram_cs,
    output logic               sram_we,
    output logic [ADDR_W-1:0]  sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic [STRB_W-1:0]  sram_wmask,
    input  logic [DATA_W-1:0]  sram_rdata
);

    generate
        if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
            $error("dmem_responder: RD_LAT out of range");
        end
    endgenerate

    typedef struct packed {
        logic              rd;
        logic              wr;
        logic              rd_err;
        logic              wr_err;
        logic [ADDR_W-1:0] rd_idx;
        logic [ADDR_W-1:0] wr_idx;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
    } req_t;

    localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

    logic [2:0]        state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    req_t              req_q, req_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_valid;
    logic              unused_addr_lsbs;

    // Byte offsets are EX's concern; only the doubleword index reaches the SRAM.
    assign unused_addr_lsbs = ^{ex.addr_mem_rd[2:0], ex.addr_mem_wr[2:0]};

    assign req_valid = (ex.mem_rd_en | ex.mem_wr_en) & ~ex.mem_except;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    req_d.rd     = ex.mem_rd_en;
                    req_d.wr     = ex.mem_wr_en;
                    req_d.rd_err = ex.mem_rd_en & addr_oob(ex.addr_mem_rd, ADDR_W);
                    req_d.wr_err = ex.mem_wr_en & addr_oob(ex.addr_mem_wr, ADDR_W);
                    req_d.rd_idx = ex.addr_mem_rd[ADDR_W+2:3];
                    req_d.wr_idx = ex.addr_mem_wr[ADDR_W+2:3];
                    req_d.wdata  = ex.data_mem_wr;
                    req_d.strb   = ex.strb_mem_wr;
                    state_d      = ex.mem_wr_en ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: state_d = req_q.rd ? ST_READ : ST_DONE;
            ST_READ: begin
                if (RD_LAT == 1) begin
                    rdata_d = req_q.rd_err ? '0 : sram_rdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = 2'd1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == LAST_CNT) begin
                    rdata_d = req_q.rd_err ? '0 : sram_rdata;
                    cnt_d   = 2'd0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            req_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
        end
    end

    // Out-of-range accesses keep their cycle slot but never strobe the SRAM.
    always_comb begin
        sram_cs        = 1'b0;
        sram_we        = 1'b0;
        sram_addr      = '0;
        sram_wdata     = '0;
        sram_wmask     = '0;
        ex.mem_wr_done = 1'b0;
        case (state_q)
            ST_WRITE: begin
                if (!req_q.wr_err) begin
                    sram_cs        = 1'b1;
                    sram_we        = 1'b1;
                    sram_addr      = req_q.wr_idx;
                    sram_wdata     = req_q.wdata;
                    sram_wmask     = req_q.strb;
                    ex.mem_wr_done = 1'b1;
                end
            end
            ST_READ: begin
                if (!req_q.rd_err) begin
                    sram_cs   = 1'b1;
                    sram_addr = req_q.rd_idx;
                end
            end
            default: ;
        endcase
    end

    assign ex.mem_stall    = ~rst & (((state_q == ST_IDLE) & req_valid) |
                                     (state_q == ST_WRITE) | (state_q == ST_READ) |
                                     (state_q == ST_WAIT));
    assign ex.mem_rd_valid = (state_q == ST_DONE) & req_q.rd;
    assign ex.mem_resp_err = (state_q == ST_DONE) & (req_q.rd_err | req_q.wr_err);
    assign ex.data_mem_rd  = rdata_q;

endmodule
